// File: rtl/spi_flash_boot_loader.sv
// Boot copier: SPI NOR READ (0x03, or FAST_READ 0x0B with SPI_BOOT_FAST_READ_EN) -> 32-bit LE words -> SRAM.
// Latency: first SCK rise CLK_DIV cycles after start_i; SCK period 2*CLK_DIV cycles.
// Backpressure: SCK parks low with CS held low until each SRAM write is acked.
module spi_flash_boot_loader #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [31:0] MEM_BASE   = 32'h00000000,
    parameter int unsigned WORD_COUNT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        spi_sck_o,
    output logic        spi_cs_no,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        wp_no,
    output logic        hold_no,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam int IDX_W = $clog2(WORD_COUNT + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SPI_BOOT_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, WRITE, FINISH, DONE
`ifdef SPI_BOOT_FAST_READ_EN
        , DUMMY
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [5:0]         field_len;
    logic [31:0]        tx_sh;
    logic [31:0]        word_q;
    logic [IDX_W-1:0]   word_idx;
    logic               shifting, tick, rise, fall, field_end, more_words, start_go;

    assign wp_no   = 1'b1;
    assign hold_no = 1'b1;

    always_comb begin
        state_d   = state_q;
        shifting  = 1'b0;
        field_len = 6'd32;
        case (state_q)
            CMD:   begin shifting = 1'b1; field_len = 6'd8;  end
            ADDR:  begin shifting = 1'b1; field_len = 6'd24; end
`ifdef SPI_BOOT_FAST_READ_EN
            DUMMY: begin shifting = 1'b1; field_len = 6'd8;  end
`endif
            DATA:  begin shifting = 1'b1; field_len = 6'd32; end
            default: ;
        endcase
        tick       = (32'(div_cnt) == CLK_DIV - 1);
        rise       = shifting && tick && !spi_sck_o;
        fall       = shifting && tick && spi_sck_o;
        field_end  = fall && (bit_cnt == field_len);
        more_words = (32'(word_idx) + 32'd1) < WORD_COUNT;
        start_go   = start_i && ((state_q == IDLE) || (state_q == DONE));
        case (state_q)
            IDLE, DONE: if (start_go) state_d = CMD;
            CMD:        if (field_end) state_d = ADDR;
`ifdef SPI_BOOT_FAST_READ_EN
            ADDR:       if (field_end) state_d = DUMMY;
            DUMMY:      if (field_end) state_d = DATA;
`else
            ADDR:       if (field_end) state_d = DATA;
`endif
            DATA:       if (field_end) state_d = WRITE;
            WRITE:      if (mem_req_o && mem_ack_i) state_d = more_words ? DATA : FINISH;
            FINISH:     if (tick) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spi_cs_no   <= 1'b1;
            spi_sck_o   <= 1'b0;
            spi_mosi_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            word_q      <= '0;
            word_idx    <= '0;
        end else begin
            spi_cs_no <= (state_d == IDLE) || (state_d == FINISH) || (state_d == DONE);
            busy_o    <= !((state_d == IDLE) || (state_d == DONE));
            done_o    <= (state_d == DONE);
            // Divider runs while shifting and during the CS-high tail; parked at 0 otherwise.
            if (shifting || state_q == FINISH) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            else                               div_cnt <= '0;
            if (rise)      spi_sck_o <= 1'b1;
            else if (fall) spi_sck_o <= 1'b0;
            if (start_go) begin
                tx_sh      <= {READ_CMD, FLASH_BASE};
                spi_mosi_o <= READ_CMD[7];
                bit_cnt    <= '0;
                word_idx   <= '0;
            end else begin
                // Zero fill drains out as MOSI=0 through dummy and data phases.
                if (fall) begin
                    tx_sh      <= {tx_sh[30:0], 1'b0};
                    spi_mosi_o <= tx_sh[30];
                end
                if (field_end) bit_cnt <= '0;
                else if (rise) bit_cnt <= bit_cnt + 6'd1;
                if (rise && state_q == DATA)
                    word_q[{bit_cnt[4:3], ~bit_cnt[2:0]}] <= spi_miso_i;
                if (state_q == DATA && state_d == WRITE) begin
                    mem_req_o   <= 1'b1;
                    mem_addr_o  <= MEM_BASE + (32'(word_idx) << 2);
                    mem_wdata_o <= word_q;
                end
                if (state_q == WRITE && mem_req_o && mem_ack_i) begin
                    mem_req_o <= 1'b0;
                    word_idx  <= word_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Directed bench: two loader instances (base-zero two-word copy, non-zero-base one-word copy) against a flash/SRAM model.
module tb_spi_flash_boot_loader;

`ifdef SPI_BOOT_FAST_READ_EN
    localparam int         HDR = 40;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         HDR = 32;
    localparam logic [7:0] CMD = 8'h03;
`endif
    localparam int EDGES_A = HDR + 64;
    localparam int EDGES_B = HDR + 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [1:0]  sck, cs_n, mosi, wp_n, hold_n, req, busy, done;
    logic [1:0]  miso = 2'b00;
    logic [1:0]  ack = 2'b00;
    logic        ack_spur = 1'b0;
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    int          stall_cfg = 0;
    logic [1:0]  sck_prev = 2'b00;
    logic [1:0]  cs_prev = 2'b11;
    int          rise_cnt [2] = '{0, 0};
    int          tot_rises [2] = '{0, 0};
    int          first_rise [2] = '{0, 0};
    int          cs_fall [2] = '{0, 0};
    int          period [2] = '{0, 0};
    logic [31:0] hdr [2] = '{32'h0, 32'h0};
    int          req_cyc [2] = '{0, 0};
    logic        req_stab [2] = '{1'b1, 1'b1};
    logic [31:0] req_a0 [2];
    logic [31:0] req_d0 [2];
    logic [31:0] wa [2][16];
    logic [31:0] wd [2][16];
    int          wlen [2][16];
    logic        wstab [2][16];
    int          wn [2] = '{0, 0};

    always #5 clk = ~clk;

    spi_flash_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h000000), .MEM_BASE(32'h0000_0000), .WORD_COUNT(2)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]),
        .spi_sck_o(sck[0]), .spi_cs_no(cs_n[0]), .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0]),
        .wp_no(wp_n[0]), .hold_no(hold_n[0]),
        .mem_req_o(req[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]), .mem_ack_i(ack[0] | ack_spur),
        .busy_o(busy[0]), .done_o(done[0]));

    spi_flash_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h012345), .MEM_BASE(32'h8000_0000), .WORD_COUNT(1)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]),
        .spi_sck_o(sck[1]), .spi_cs_no(cs_n[1]), .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1]),
        .wp_no(wp_n[1]), .hold_no(hold_n[1]),
        .mem_req_o(req[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]), .mem_ack_i(ack[1]),
        .busy_o(busy[1]), .done_o(done[1]));

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h11;
            24'h000001: return 8'h22;
            24'h000002: return 8'h33;
            24'h000003: return 8'h44;
            24'h000004: return 8'h55;
            24'h000005: return 8'h66;
            24'h000006: return 8'h77;
            24'h000007: return 8'h88;
            24'h012345: return 8'hA1;
            24'h012346: return 8'hB2;
            24'h012347: return 8'hC3;
            24'h012348: return 8'hD4;
            default:    return 8'hEE;
        endcase
    endfunction

    // Flash serves bytes from the address it actually received on MOSI.
    function automatic logic flash_bit(input logic [31:0] h, input int rc);
        int d;
        logic [7:0] b;
        if (rc < HDR) return 1'b0;
        d = rc - HDR;
        b = flash_byte(h[23:0] + 24'(d / 8));
        return b[7 - (d % 8)];
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (!cs_n[g] && cs_prev[g]) begin
                cs_fall[g]  = cyc;
                rise_cnt[g] = 0;
                hdr[g]      = 32'h0;
            end
            if (!cs_n[g] && sck[g] && !sck_prev[g]) begin
                if (rise_cnt[g] < 32) hdr[g] = {hdr[g][30:0], mosi[g]};
                rise_cnt[g]++;
                tot_rises[g]++;
                if (rise_cnt[g] == 1) first_rise[g] = cyc;
                if (rise_cnt[g] == 2) period[g] = cyc - first_rise[g];
            end
            sck_prev[g] = sck[g];
            cs_prev[g]  = cs_n[g];
            miso[g]     = flash_bit(hdr[g], rise_cnt[g]);
            if (req[g]) begin
                if (req_cyc[g] == 0) begin
                    req_a0[g]   = maddr[g];
                    req_d0[g]   = mwdata[g];
                    req_stab[g] = !sck[g] && !cs_n[g];
                end else if (maddr[g] !== req_a0[g] || mwdata[g] !== req_d0[g] || sck[g] || cs_n[g]) begin
                    req_stab[g] = 1'b0;
                end
                ack[g] = (req_cyc[g] >= stall_cfg);
                if (ack[g] && wn[g] < 16) begin
                    wa[g][wn[g]]    = maddr[g];
                    wd[g][wn[g]]    = mwdata[g];
                    wlen[g][wn[g]]  = req_cyc[g] + 1;
                    wstab[g][wn[g]] = req_stab[g];
                    wn[g]++;
                end
                req_cyc[g]++;
            end else begin
                ack[g]     = 1'b0;
                req_cyc[g] = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input string name);
        int n;
        n = 0;
        while (!done[g] && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (done[g] !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done[g], n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cs_n, sck, mosi, req, busy, done, wp_n, hold_n} !== 16'b11_00_00_00_00_00_11_11) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required %b", {cs_n, sck, mosi, req, busy, done, wp_n, hold_n},
                     16'b11_00_00_00_00_00_11_11);
        end
        checks++;
        if ({maddr[0], mwdata[0], maddr[1], mwdata[1]} !== 128'h0) begin
            failures++;
            $display("FAIL reset_bus: got %h, required 0", {maddr[0], mwdata[0], maddr[1], mwdata[1]});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_copy();
        int r0, w0;
        r0 = tot_rises[0];
        w0 = wn[0];
        pulse_start(0);
        checks++;
        if ({busy[0], done[0], cs_n[0]} !== 3'b100) begin
            failures++;
            $display("FAIL start_resp: busy,done,cs_n=%b, required 100", {busy[0], done[0], cs_n[0]});
        end
        wait_done(0, "basic");
        checks++;
        if (hdr[0] !== {CMD, 24'h000000}) begin
            failures++;
            $display("FAIL basic_mosi: got %h, required %h", hdr[0], {CMD, 24'h000000});
        end
        checks++;
        if (tot_rises[0] - r0 !== EDGES_A) begin
            failures++;
            $display("FAIL basic_edges: got %0d, required %0d", tot_rises[0] - r0, EDGES_A);
        end
        checks++;
        if (wn[0] - w0 !== 2) begin
            failures++;
            $display("FAIL basic_nwrites: got %0d, required 2", wn[0] - w0);
        end
        checks++;
        if ({wa[0][w0], wd[0][w0]} !== 64'h00000000_44332211) begin
            failures++;
            $display("FAIL basic_w0: got %h, required 00000000_44332211", {wa[0][w0], wd[0][w0]});
        end
        checks++;
        if ({wa[0][w0+1], wd[0][w0+1]} !== 64'h00000004_88776655) begin
            failures++;
            $display("FAIL basic_w1: got %h, required 00000004_88776655", {wa[0][w0+1], wd[0][w0+1]});
        end
        checks++;
        if (period[0] !== 4) begin
            failures++;
            $display("FAIL sck_period: got %0d cycles, required 4", period[0]);
        end
        checks++;
        if (first_rise[0] - cs_fall[0] !== 2) begin
            failures++;
            $display("FAIL first_rise_lead: got %0d cycles, required 2", first_rise[0] - cs_fall[0]);
        end
        checks++;
        if ({done[0], busy[0], cs_n[0], sck[0]} !== 4'b1010) begin
            failures++;
            $display("FAIL basic_end: done,busy,cs_n,sck=%b, required 1010", {done[0], busy[0], cs_n[0], sck[0]});
        end
    endtask

    task automatic test_ack_stall();
        int w0, n;
        w0 = wn[0];
        stall_cfg = 7;
        pulse_start(0);
        n = 0;
        while (wn[0] == w0 && n < 3000) begin
            tick();
            n++;
        end
        stall_cfg = 0;
        wait_done(0, "stall");
        checks++;
        if (wn[0] - w0 !== 2) begin
            failures++;
            $display("FAIL stall_nwrites: got %0d, required 2", wn[0] - w0);
        end
        checks++;
        if (wlen[0][w0] !== 8) begin
            failures++;
            $display("FAIL stall_req_len: got %0d cycles, required 8", wlen[0][w0]);
        end
        checks++;
        if (wstab[0][w0] !== 1'b1) begin
            failures++;
            $display("FAIL stall_stable: got %b, required 1", wstab[0][w0]);
        end
        checks++;
        if ({wd[0][w0], wd[0][w0+1]} !== 64'h44332211_88776655) begin
            failures++;
            $display("FAIL stall_data: got %h, required 44332211_88776655", {wd[0][w0], wd[0][w0+1]});
        end
        checks++;
        if (wlen[0][w0+1] !== 1) begin
            failures++;
            $display("FAIL stall_w1_len: got %0d cycles, required 1", wlen[0][w0+1]);
        end
    endtask

    task automatic test_reset_mid();
        int w0, n;
        w0 = wn[0];
        pulse_start(0);
        n = 0;
        while (rise_cnt[0] < 40 && n < 3000) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({cs_n[0], sck[0], req[0], busy[0], done[0]} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_out: cs_n,sck,req,busy,done=%b, required 10000",
                     {cs_n[0], sck[0], req[0], busy[0], done[0]});
        end
        checks++;
        if (wn[0] !== w0) begin
            failures++;
            $display("FAIL midreset_nowrite: got %0d writes, required 0", wn[0] - w0);
        end
        rst = 1'b0;
        tick();
        pulse_start(0);
        wait_done(0, "after_reset");
        checks++;
        if ({wa[0][w0], wd[0][w0], wa[0][w0+1], wd[0][w0+1]} !== 128'h00000000_44332211_00000004_88776655) begin
            failures++;
            $display("FAIL midreset_recopy: got %h, required 00000000_44332211_00000004_88776655",
                     {wa[0][w0], wd[0][w0], wa[0][w0+1], wd[0][w0+1]});
        end
    endtask

    task automatic test_start_handling();
        int r0, w0;
        r0 = tot_rises[0];
        w0 = wn[0];
        pulse_start(0);
        repeat (50) tick();
        pulse_start(0);
        ack_spur = 1'b1;
        tick();
        ack_spur = 1'b0;
        wait_done(0, "busy_start");
        checks++;
        if (tot_rises[0] - r0 !== EDGES_A || wn[0] - w0 !== 2) begin
            failures++;
            $display("FAIL busy_start_ignored: edges=%0d writes=%0d, required %0d and 2",
                     tot_rises[0] - r0, wn[0] - w0, EDGES_A);
        end
        checks++;
        if ({wd[0][w0], wd[0][w0+1]} !== 64'h44332211_88776655) begin
            failures++;
            $display("FAIL busy_start_data: got %h, required 44332211_88776655", {wd[0][w0], wd[0][w0+1]});
        end
        pulse_start(0);
        checks++;
        if ({done[0], busy[0]} !== 2'b01) begin
            failures++;
            $display("FAIL restart_clear: done,busy=%b, required 01", {done[0], busy[0]});
        end
        wait_done(0, "restart");
        checks++;
        if ({wa[0][w0+2], wd[0][w0+2], wa[0][w0+3], wd[0][w0+3]} !== 128'h00000000_44332211_00000004_88776655) begin
            failures++;
            $display("FAIL restart_writes: got %h, required 00000000_44332211_00000004_88776655",
                     {wa[0][w0+2], wd[0][w0+2], wa[0][w0+3], wd[0][w0+3]});
        end
        checks++;
        if (tot_rises[0] - r0 !== 2 * EDGES_A) begin
            failures++;
            $display("FAIL restart_edges: got %0d, required %0d", tot_rises[0] - r0, 2 * EDGES_A);
        end
    endtask

    task automatic test_nonzero_base();
        int r0, w0;
        r0 = tot_rises[1];
        w0 = wn[1];
        pulse_start(1);
        wait_done(1, "nonzero");
        checks++;
        if (hdr[1] !== {CMD, 24'h012345}) begin
            failures++;
            $display("FAIL nz_mosi: got %h, required %h", hdr[1], {CMD, 24'h012345});
        end
        checks++;
        if (wn[1] - w0 !== 1) begin
            failures++;
            $display("FAIL nz_nwrites: got %0d, required 1", wn[1] - w0);
        end
        checks++;
        if ({wa[1][w0], wd[1][w0]} !== 64'h80000000_D4C3B2A1) begin
            failures++;
            $display("FAIL nz_write: got %h, required 80000000_D4C3B2A1", {wa[1][w0], wd[1][w0]});
        end
        checks++;
        if (tot_rises[1] - r0 !== EDGES_B) begin
            failures++;
            $display("FAIL nz_edges: got %0d, required %0d", tot_rises[1] - r0, EDGES_B);
        end
        checks++;
        if ({done[1], busy[1]} !== 2'b10) begin
            failures++;
            $display("FAIL nz_end: done,busy=%b, required 10", {done[1], busy[1]});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_copy();
        test_ack_stall();
        test_reset_mid();
        test_start_handling();
        test_nonzero_base();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
